// File: rtl/stride_burst_writer_pkg.sv
// stride_burst_writer_pkg
//   Shared definitions for the stride burst writer: FSM state encoding,
//   4 KiB page constants and small sizing helpers used by the top and
//   the burst FIFO.
package stride_burst_writer_pkg;

  // Writer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // 4 KiB page: bursts may not cross it when the split feature is built.
  localparam int PAGE_BYTES    = 4096;
  localparam int PAGE_OFFSET_W = 12;

  // Bytes carried by one stream beat.
  function automatic int bytes_per_beat(input int data_width);
    return data_width / 8;
  endfunction

  // Counter width able to hold 0..burst_len inclusive.
  function automatic int cnt_width(input int burst_len);
    return $clog2(burst_len + 1);
  endfunction

  // Minimum Cmd_Len width: must encode burst_len-1.
  function automatic int len_width_for(input int burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/stride_burst_fifo.sv
// stride_burst_fifo
//   Synchronous first-word fall-through FIFO holding one burst of beats.
//   The head entry is visible on o_rd_data whenever o_empty is low; a read
//   pops it. DEPTH must be a power of two so the pointers wrap naturally.
// Ports:
//   clk, rst          clock, asynchronous active-high reset (clears pointers)
//   i_wr_en/i_wr_data push one entry (ignored when full)
//   i_rd_en           pop the head entry (ignored when empty)
//   o_rd_data         head entry (undefined while empty)
//   o_empty/o_full    occupancy flags
module stride_burst_fifo
  import stride_burst_writer_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = i_wr_en && !o_full;
  assign w_rd = i_rd_en && !o_empty;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage carries no reset: contents are meaningless once pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/stride_burst_writer.sv
// stride_burst_writer
//   Cuts a packed beat stream into bursts of at most BURST_LEN beats for a
//   DMA write engine. Each burst is first collected into a local FIFO, then
//   one write command (address, beats-1) is issued, then the buffered beats
//   are drained with M_Last on the final beat of the burst. The destination
//   address starts at Base_Addr (latched by Start) and advances by the
//   burst size after each burst. Write_Complete pulses once the burst that
//   carried the frame-last beat has fully drained.
//
//   Optional feature (macro STRIDE_BURST_4K_SPLIT_EN): the per-burst limit is
//   shortened so that no burst crosses a 4 KiB page boundary.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   Start, Base_Addr         arm the block and latch the frame base address
//   S_Data/S_Valid/S_Ready/S_Last   input beat stream with frame-last marker
//   Cmd_Valid/Cmd_Ready/Cmd_Addr/Cmd_Len   write command (Cmd_Len = beats-1)
//   M_Data/M_Valid/M_Ready/M_Last   output beat stream, M_Last ends a burst
//   Write_Complete           one-cycle pulse after the frame drains
//   Busy                     high whenever the FSM is not IDLE
//
// Handshakes: every channel transfers on a clock edge where valid and ready
// are both high. Once a valid is raised, it and its payload stay unchanged
// until that transfer happens; ready may toggle freely.
module stride_burst_writer
  import stride_burst_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] Base_Addr,
  input  logic [DATA_WIDTH-1:0] S_Data,
  input  logic                  S_Valid,
  output logic                  S_Ready,
  input  logic                  S_Last,
  output logic                  Cmd_Valid,
  input  logic                  Cmd_Ready,
  output logic [ADDR_WIDTH-1:0] Cmd_Addr,
  output logic [LEN_WIDTH-1:0]  Cmd_Len,
  output logic [DATA_WIDTH-1:0] M_Data,
  output logic                  M_Valid,
  input  logic                  M_Ready,
  output logic                  M_Last,
  output logic                  Write_Complete,
  output logic                  Busy
);

  localparam int BYTES_PER_BEAT = bytes_per_beat(DATA_WIDTH);
  localparam int CNT_W          = cnt_width(BURST_LEN);
  localparam int MIN_LEN_W      = len_width_for(BURST_LEN);

  if (LEN_WIDTH < MIN_LEN_W) begin : g_len_width_check
    $error("LEN_WIDTH cannot encode BURST_LEN-1");
  end

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [CNT_W-1:0]      r_drain_cnt;
  logic                  r_frame_done;
  logic                  r_cmd_valid;
  logic [ADDR_WIDTH-1:0] r_cmd_addr;
  logic [LEN_WIDTH-1:0]  r_cmd_len;
  logic [CNT_W-1:0]      w_burst_limit;

  logic                  w_s_ready;
  logic                  w_s_accept;
  logic                  w_burst_end;
  logic                  w_cmd_fire;
  logic                  w_m_valid;
  logic                  w_m_last;
  logic                  w_m_accept;
  logic                  w_last_fire;
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic [DATA_WIDTH-1:0] w_fifo_head;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;

  // ------------------------------------------------------------------
  // Burst limit
  // ------------------------------------------------------------------
`ifdef STRIDE_BURST_4K_SPLIT_EN
  logic [CNT_W-1:0] r_burst_limit;

  // Beats that fit before the next 4 KiB boundary, capped at BURST_LEN.
  // Addresses are beat-aligned, so at least one beat always fits.
  function automatic logic [CNT_W-1:0] limit_for(input logic [ADDR_WIDTH-1:0] addr);
    logic [PAGE_OFFSET_W:0] room_bytes;
    logic [PAGE_OFFSET_W:0] room_beats;
    room_bytes = (PAGE_OFFSET_W+1)'(PAGE_BYTES) - {1'b0, addr[PAGE_OFFSET_W-1:0]};
    room_beats = room_bytes / (PAGE_OFFSET_W+1)'(BYTES_PER_BEAT);
    if (room_beats >= (PAGE_OFFSET_W+1)'(BURST_LEN)) begin
      return CNT_W'(BURST_LEN);
    end
    return CNT_W'(room_beats);
  endfunction

  // Recomputed on every entry to COLLECT from the address the burst will use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_burst_limit <= '0;
    end else if (r_state == ST_IDLE && Start) begin
      r_burst_limit <= limit_for(Base_Addr);
    end else if (w_last_fire) begin
      r_burst_limit <= limit_for(w_next_addr);
    end
  end

  assign w_burst_limit = r_burst_limit;
`else
  assign w_burst_limit = CNT_W'(BURST_LEN);
`endif

  // ------------------------------------------------------------------
  // Handshake decode
  // ------------------------------------------------------------------
  assign w_s_ready  = (r_state == ST_COLLECT) && (r_beat_cnt < w_burst_limit) && !w_fifo_full;
  assign w_s_accept = S_Valid && w_s_ready;
  // A burst closes on the beat that reaches the limit or carries S_Last;
  // when both coincide it still closes only once.
  assign w_burst_end = w_s_accept && (((r_beat_cnt + CNT_W'(1)) == w_burst_limit) || S_Last);
  assign w_cmd_fire  = r_cmd_valid && Cmd_Ready;

  // Beats are only offered in DRAIN, i.e. after the command was accepted.
  assign w_m_valid   = (r_state == ST_DRAIN) && !w_fifo_empty;
  assign w_m_last    = w_m_valid && (r_drain_cnt == (r_beat_cnt - CNT_W'(1)));
  assign w_m_accept  = w_m_valid && M_Ready;
  assign w_last_fire = w_m_accept && w_m_last;

  // Address of the next burst; wraps modulo 2^ADDR_WIDTH.
  assign w_next_addr = r_cur_addr + (ADDR_WIDTH'(r_beat_cnt) * ADDR_WIDTH'(BYTES_PER_BEAT));

  // ------------------------------------------------------------------
  // Burst buffer
  // ------------------------------------------------------------------
  stride_burst_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (BURST_LEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_s_accept),
    .i_wr_data (S_Data),
    .i_rd_en   (w_m_accept),
    .o_rd_data (w_fifo_head),
    .o_empty   (w_fifo_empty),
    .o_full    (w_fifo_full)
  );

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_burst_end) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_cmd_fire) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_last_fire) begin
          w_state_next = r_frame_done ? ST_DONE : ST_COLLECT;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Counters, address and frame flag
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur_addr   <= '0;
      r_beat_cnt   <= '0;
      r_drain_cnt  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && Start) begin
        r_cur_addr <= Base_Addr;
      end else if (w_last_fire) begin
        r_cur_addr <= w_next_addr;
      end

      if (w_last_fire) begin
        r_beat_cnt <= '0;
      end else if (w_s_accept) begin
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end

      if (w_last_fire) begin
        r_drain_cnt <= '0;
      end else if (w_m_accept) begin
        r_drain_cnt <= r_drain_cnt + CNT_W'(1);
      end

      if (w_s_accept && S_Last) begin
        r_frame_done <= 1'b1;
      end else if (r_state == ST_DONE) begin
        r_frame_done <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Command register: loaded as the burst closes, held until accepted.
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
    end else if (r_state == ST_COLLECT && w_burst_end) begin
      r_cmd_valid <= 1'b1;
      r_cmd_addr  <= r_cur_addr;
      // The closing beat is not yet counted, so the pre-increment count
      // is already "beats minus one".
      r_cmd_len   <= LEN_WIDTH'(r_beat_cnt);
    end else if (w_cmd_fire) begin
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_len   <= '0;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign S_Ready        = w_s_ready;
  assign Cmd_Valid      = r_cmd_valid;
  assign Cmd_Addr       = r_cmd_addr;
  assign Cmd_Len        = r_cmd_len;
  // Data is zeroed while not valid so stale FIFO storage never shows.
  assign M_Data         = w_m_valid ? w_fifo_head : '0;
  assign M_Valid        = w_m_valid;
  assign M_Last         = w_m_last;
  assign Write_Complete = (r_state == ST_DONE);
  assign Busy           = (r_state != ST_IDLE);

endmodule
